// File: rtl/stm_idx_gen_pkg.sv
// rtl/stm_idx_gen_pkg.sv - shared constants for the STM index generator
package stm_idx_gen_pkg;

  localparam int STM_IDX_WIDTH = 16;

endpackage

// File: rtl/stm_idx_gen_if.sv
// rtl/stm_idx_gen_if.sv - settings/sync inputs and index/tick outputs of the STM index generator
interface stm_idx_gen_if
  import stm_idx_gen_pkg::*;
#(
  parameter int WIDTH = STM_IDX_WIDTH
);

  logic             UPDATE_SETTINGS;
  logic             SYNC;
  logic [WIDTH-1:0] CYCLE_0;
  logic [WIDTH-1:0] FREQ_DIV_0;
  logic [WIDTH-1:0] CYCLE_1;
  logic [WIDTH-1:0] FREQ_DIV_1;
  logic [WIDTH-1:0] IDX_0;
  logic [WIDTH-1:0] IDX_1;
  logic             TICK_0;
  logic             TICK_1;

  modport master (
    output UPDATE_SETTINGS, SYNC, CYCLE_0, FREQ_DIV_0, CYCLE_1, FREQ_DIV_1,
    input  IDX_0, IDX_1, TICK_0, TICK_1
  );

  modport slave (
    input  UPDATE_SETTINGS, SYNC, CYCLE_0, FREQ_DIV_0, CYCLE_1, FREQ_DIV_1,
    output IDX_0, IDX_1, TICK_0, TICK_1
  );

endinterface

// File: rtl/stm_idx_gen_counter.sv
// rtl/stm_idx_gen_counter.sv - one STM segment: prescaler plus wrapping index counter
module stm_idx_counter
  import stm_idx_gen_pkg::*;
#(
  parameter int WIDTH = STM_IDX_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UPDATE_SETTINGS,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] CYCLE,
  input  logic [WIDTH-1:0] FREQ_DIV,
  output logic [WIDTH-1:0] IDX,
  output logic             TICK
);

  logic [WIDTH-1:0] r_cyc;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_idx;
  logic             r_tick;

  logic [WIDTH-1:0] w_div_eff;
  logic             w_advance;
  logic [WIDTH-1:0] w_idx_next;

  // A divider of zero behaves like one so the segment never stalls.
  assign w_div_eff  = (r_div == '0) ? WIDTH'(1) : r_div;
  assign w_advance  = (r_d >= (w_div_eff - WIDTH'(1)));
  assign w_idx_next = (r_idx >= r_cyc) ? '0 : (r_idx + WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cyc  <= '0;
      r_div  <= '0;
      r_d    <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
    end else if (SYNC) begin
      r_d    <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      if (UPDATE_SETTINGS) begin
        r_cyc <= CYCLE;
        r_div <= FREQ_DIV;
      end
    end else begin
      if (UPDATE_SETTINGS) begin
        r_cyc <= CYCLE;
        r_div <= FREQ_DIV;
      end
      // A shrunk cycle that leaves the index out of range restarts the segment;
      // otherwise this edge still steps with the old cyc/div.
      if (UPDATE_SETTINGS && (r_idx > CYCLE)) begin
        r_idx  <= '0;
        r_d    <= '0;
        r_tick <= 1'b1;
      end else if (w_advance) begin
        r_d    <= '0;
        r_idx  <= w_idx_next;
        r_tick <= 1'b1;
      end else begin
        r_d    <= r_d + WIDTH'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign IDX  = r_idx;
  assign TICK = r_tick;

endmodule

// File: rtl/stm_idx_gen.sv
// rtl/stm_idx_gen.sv - two independent STM segment index counters sharing reset, sync and update
module stm_idx_gen
  import stm_idx_gen_pkg::*;
#(
  parameter int WIDTH = STM_IDX_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  stm_idx_gen_if.slave bus
);

  logic [WIDTH-1:0] w_idx_0;
  logic [WIDTH-1:0] w_idx_1;
  logic             w_tick_0;
  logic             w_tick_1;

  stm_idx_counter #(.WIDTH(WIDTH)) u_seg0 (
    .CLK             (CLK),
    .RST             (RST),
    .UPDATE_SETTINGS (bus.UPDATE_SETTINGS),
    .SYNC            (bus.SYNC),
    .CYCLE           (bus.CYCLE_0),
    .FREQ_DIV        (bus.FREQ_DIV_0),
    .IDX             (w_idx_0),
    .TICK            (w_tick_0)
  );

  stm_idx_counter #(.WIDTH(WIDTH)) u_seg1 (
    .CLK             (CLK),
    .RST             (RST),
    .UPDATE_SETTINGS (bus.UPDATE_SETTINGS),
    .SYNC            (bus.SYNC),
    .CYCLE           (bus.CYCLE_1),
    .FREQ_DIV        (bus.FREQ_DIV_1),
    .IDX             (w_idx_1),
    .TICK            (w_tick_1)
  );

  assign bus.IDX_0  = w_idx_0;
  assign bus.IDX_1  = w_idx_1;
  assign bus.TICK_0 = w_tick_0;
  assign bus.TICK_1 = w_tick_1;

endmodule

// File: tb/tb_stm_idx_gen.sv
// tb/tb_stm_idx_gen.sv - randomized and directed checks of stm_idx_gen against a behavioural model
module tb_stm_idx_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stm_idx_gen_if #(.WIDTH(16)) bus ();

  stm_idx_gen #(.WIDTH(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  longint m_cyc [2] = '{0, 0};
  longint m_div [2] = '{0, 0};
  longint m_cnt [2] = '{0, 0};
  longint m_idx [2] = '{0, 0};
  longint m_tick[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Clocks spent on the current entry versus clocks per entry.
  task automatic model_count(input int s, input longint c, input longint dv);
    longint per;
    per = (dv == 0) ? 1 : dv;
    if (m_cnt[s] + 1 >= per) begin
      m_cnt[s]  = 0;
      m_idx[s]  = (m_idx[s] >= c) ? 0 : m_idx[s] + 1;
      m_tick[s] = 1;
    end else begin
      m_cnt[s]  = m_cnt[s] + 1;
      m_tick[s] = 0;
    end
  endtask

  task automatic model_seg(input int s, input bit r, input bit sy, input bit up,
                           input longint nc, input longint nd);
    longint oc, od;
    oc = m_cyc[s];
    od = m_div[s];
    if (r) begin
      m_cyc[s] = 0; m_div[s] = 0; m_cnt[s] = 0; m_idx[s] = 0; m_tick[s] = 0;
    end else if (sy) begin
      m_cnt[s] = 0; m_idx[s] = 0; m_tick[s] = 0;
      if (up) begin m_cyc[s] = nc; m_div[s] = nd; end
    end else if (up) begin
      m_cyc[s] = nc; m_div[s] = nd;
      if (m_idx[s] > nc) begin
        m_idx[s] = 0; m_cnt[s] = 0; m_tick[s] = 1;
      end else begin
        model_count(s, oc, od);
      end
    end else begin
      model_count(s, oc, od);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_seg(0, rst, bus.SYNC, bus.UPDATE_SETTINGS, longint'(bus.CYCLE_0), longint'(bus.FREQ_DIV_0));
    model_seg(1, rst, bus.SYNC, bus.UPDATE_SETTINGS, longint'(bus.CYCLE_1), longint'(bus.FREQ_DIV_1));
    chk("idx0",  32'(bus.IDX_0),  32'(m_idx[0]));
    chk("idx1",  32'(bus.IDX_1),  32'(m_idx[1]));
    chk("tick0", 32'(bus.TICK_0), 32'(m_tick[0]));
    chk("tick1", 32'(bus.TICK_1), 32'(m_tick[1]));
  endtask

  task automatic pulse(input bit up, input bit sy);
    bus.UPDATE_SETTINGS = up;
    bus.SYNC            = sy;
    step();
    bus.UPDATE_SETTINGS = 1'b0;
    bus.SYNC            = 1'b0;
  endtask

  int seq0 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    bus.UPDATE_SETTINGS = 1'b0;
    bus.SYNC            = 1'b0;
    bus.CYCLE_0         = '0;
    bus.FREQ_DIV_0      = '0;
    bus.CYCLE_1         = '0;
    bus.FREQ_DIV_1      = '0;

    step();
    step();
    chk("rst_idx0", 32'(bus.IDX_0), 0);
    chk("rst_idx1", 32'(bus.IDX_1), 0);
    chk("rst_tick0", 32'(bus.TICK_0), 0);
    chk("rst_tick1", 32'(bus.TICK_1), 0);
    rst = 1'b0;

    // cyc 3 / div 2 on segment 0, segment 1 left at cyc 0
    bus.CYCLE_0 = 16'd3; bus.FREQ_DIV_0 = 16'd2;
    pulse(1'b1, 1'b0);
    repeat (3) step();
    pulse(1'b0, 1'b1);
    chk("seq0_0", 32'(bus.IDX_0), 32'(seq0[0]));
    for (int i = 1; i < 10; i++) begin
      step();
      chk("seq0", 32'(bus.IDX_0), 32'(seq0[i]));
      chk("seq0_tick", 32'(bus.TICK_0), (seq0[i] != seq0[i-1]) ? 32'd1 : 32'd0);
      chk("seq0_idx1", 32'(bus.IDX_1), 0);
    end

    // segment 1 at div 0 -> one entry per clock
    bus.CYCLE_1 = 16'd4; bus.FREQ_DIV_1 = 16'd0;
    pulse(1'b1, 1'b1);
    chk("div0_sync", 32'(bus.IDX_1), 0);
    for (int i = 1; i < 12; i++) begin
      step();
      chk("div0_idx1", 32'(bus.IDX_1), 32'(i % 5));
      chk("div0_tick1", 32'(bus.TICK_1), 1);
    end

    // shrink cycle below the current index
    bus.CYCLE_0 = 16'd20; bus.FREQ_DIV_0 = 16'd3;
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 200 && bus.IDX_0 != 16'd10; i++) step();
    chk("reach10", 32'(bus.IDX_0), 10);
    bus.CYCLE_0 = 16'd5;
    pulse(1'b1, 1'b0);
    chk("shrink_idx0", 32'(bus.IDX_0), 0);
    chk("shrink_tick0", 32'(bus.TICK_0), 1);
    repeat (30) step();

    // sync together with a divider change 4 -> 1
    bus.CYCLE_0 = 16'd9; bus.FREQ_DIV_0 = 16'd4;
    pulse(1'b1, 1'b0);
    repeat (10) step();
    bus.FREQ_DIV_0 = 16'd1;
    pulse(1'b1, 1'b1);
    chk("syncupd_idx0", 32'(bus.IDX_0), 0);
    chk("syncupd_tick0", 32'(bus.TICK_0), 0);
    step();
    chk("syncupd_adv1", 32'(bus.IDX_0), 1);
    chk("syncupd_tick1", 32'(bus.TICK_0), 1);
    step();
    chk("syncupd_adv2", 32'(bus.IDX_0), 2);

    // reset mid-count
    bus.CYCLE_0 = 16'd20; bus.FREQ_DIV_0 = 16'd1;
    bus.CYCLE_1 = 16'd5;  bus.FREQ_DIV_1 = 16'd3;
    pulse(1'b1, 1'b1);
    repeat (7) step();
    chk("pre_rst_idx0", 32'(bus.IDX_0), 7);
    chk("pre_rst_idx1", 32'(bus.IDX_1), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_idx0", 32'(bus.IDX_0), 0);
    chk("mid_rst_idx1", 32'(bus.IDX_1), 0);
    chk("mid_rst_tick0", 32'(bus.TICK_0), 0);
    chk("mid_rst_tick1", 32'(bus.TICK_1), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_idx0", 32'(bus.IDX_0), 0);
      chk("post_rst_idx1", 32'(bus.IDX_1), 0);
    end

    // full-range cycle wraps 0xFFFF -> 0
    bus.CYCLE_0 = 16'hFFFF; bus.FREQ_DIV_0 = 16'd1;
    pulse(1'b1, 1'b1);
    repeat (65534) step();
    chk("max_fffe", 32'(bus.IDX_0), 32'hFFFE);
    step();
    chk("max_ffff", 32'(bus.IDX_0), 32'hFFFF);
    step();
    chk("max_wrap", 32'(bus.IDX_0), 0);
    chk("max_wrap_tick", 32'(bus.TICK_0), 1);

    // randomized settings, syncs and resets
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.SYNC = ($urandom_range(0, 39) == 0);
      bus.UPDATE_SETTINGS = ($urandom_range(0, 19) == 0);
      if (bus.UPDATE_SETTINGS) begin
        bus.CYCLE_0    = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
        bus.CYCLE_1    = 16'($urandom_range(0, 12));
        bus.FREQ_DIV_0 = 16'($urandom_range(0, 5));
        bus.FREQ_DIV_1 = 16'($urandom_range(0, 5));
      end
      step();
    end
    rst = 1'b0;
    bus.SYNC = 1'b0;
    bus.UPDATE_SETTINGS = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stm_idx_gen.md
# stm_idx_gen

Generates the two per-segment STM sample indices that feed the STM swapchain's `IDX_0_IN` and `IDX_1_IN` inputs. Each segment has an independent prescaler (clocks per entry) and an index counter that wraps at a programmable last index. Both segments run continuously, so the swapchain can switch segments or count loops at any time. A sync pulse zeroes both segments together, which aligns them across devices.

## Interface
Parameters:
- `WIDTH`, 16: index / cycle / divider width.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous active-high reset.
- `UPDATE_SETTINGS`  in  1  one-cycle pulse; loads `CYCLE_*`/`FREQ_DIV_*` into the active registers.
- `SYNC`  in  1  one-cycle pulse; zeroes prescalers and indices of both segments.
- `CYCLE_0`  in  WIDTH  segment 0 last index (entries − 1).
- `FREQ_DIV_0`  in  WIDTH  segment 0 clocks per entry; 0 is treated as 1.
- `CYCLE_1`  in  WIDTH  segment 1 last index.
- `FREQ_DIV_1`  in  WIDTH  segment 1 clocks per entry; 0 is treated as 1.
- `IDX_0`  out  WIDTH  segment 0 index, registered.
- `IDX_1`  out  WIDTH  segment 1 index, registered.
- `TICK_0`  out  1  one-cycle pulse; asserted in the cycle in which `IDX_0` holds a newly advanced value.
- `TICK_1`  out  1  same as `TICK_0`, for segment 1.

## Operation
Per-segment state:
- active `cyc`, active `div`, prescaler `d`, index `idx`.
- `div_eff = (div == 0) ? 1 : div`.

Each clock, in priority order:
1. `RST`: `cyc = 0`, `div = 0`, `d = 0`, `idx = 0`, `TICK = 0`.
2. `SYNC`, with or without `UPDATE_SETTINGS`:
   - `d = 0`, `idx = 0`, `TICK = 0`.
   - If `UPDATE_SETTINGS` is also high, the new `cyc`/`div` are latched on the same edge.
3. `UPDATE_SETTINGS` alone:
   - Latch the new `cyc`/`div`.
   - If current `idx > new cyc`: `idx = 0`, `d = 0`, `TICK = 1`.
   - Otherwise counting continues. The wrap test on this edge uses the old values; the new values apply from the next edge.
   - If `d >= new div_eff − 1`, the next edge advances.
4. Normal counting:
   - If `d >= div_eff − 1`: `d = 0`; `idx = (idx >= cyc) ? 0 : idx + 1`; `TICK = 1`.
   - Otherwise: `d = d + 1`; `TICK = 0`.

Boundary rules:
- `cyc == 0`: `idx` stays at 0. `TICK` still pulses every `div_eff` clocks.
- `cyc = 2^WIDTH − 1`: the index wraps naturally from 0xFFFF to 0. There is no carry out.
- `div_eff == 1`: the index advances every clock and `TICK` stays high continuously.
- Segments are fully independent. No cross-segment interaction except the shared `SYNC`/`RST`/`UPDATE_SETTINGS`.
- The `>=` comparisons guarantee recovery if a parameter update shrinks `cyc` or `div` below the current count.

## Timing
- All outputs are registered. Reset values: `IDX_* = 0`, `TICK_* = 0`.
- `SYNC` sampled at edge t:
  - `IDX = 0` after t.
  - First advance at edge t + `div_eff`: `IDX = 1` and `TICK = 1` for exactly one cycle (when `div_eff` > 1).
- Steady state: each index value is held for exactly `div_eff` clocks.
- Wrap from `cyc` to 0 has the same timing as any other advance. `TICK` is high in the cycle after the wrap.
- Latency from the input parameter change to its effect is one edge (the `UPDATE_SETTINGS` edge).

## Structure
- Package `params`: add `STM_IDX_WIDTH = 16`. No new typedefs.
- Sub-module `stm_idx_counter`:
  - One segment: prescaler, index, update/sync/reset logic.
  - Ports: `CLK`, `RST`, `UPDATE_SETTINGS`, `SYNC`, `CYCLE`, `FREQ_DIV`, `IDX`, `TICK`.
  - Instantiated twice by `stm_idx_gen`. The top level only wires the two instances.

## Test plan
- Reset release, then `UPDATE_SETTINGS` with `CYCLE_0 = 3`, `FREQ_DIV_0 = 2`, then `SYNC` → `IDX_0` runs 0,0,1,1,2,2,3,3,0,…; `TICK_0` on each change; `IDX_1` stays 0.
- `FREQ_DIV_1 = 0`, `CYCLE_1 = 4`, after `SYNC` → `IDX_1` runs 0,1,2,3,4,0,… every clock; `TICK_1` constantly 1 after the first advance.
- While `IDX_0 = 10` with `CYCLE_0 = 20`, pulse `UPDATE_SETTINGS` with `CYCLE_0 = 5` → `IDX_0 = 0` next cycle, `TICK_0 = 1`, then counting continues up to 5.
- `SYNC` and `UPDATE_SETTINGS` asserted together (`FREQ_DIV_0` changes 4 → 1) → `IDX_0 = 0` next cycle, then advances every clock.
- `RST` asserted mid-count (`IDX_0 = 7`, `IDX_1 = 2`) → both 0, ticks 0, next cycle. Active registers cleared, so both indices stay 0 until the next `UPDATE_SETTINGS`.
- `CYCLE_0 = 0xFFFF`, `FREQ_DIV_0 = 1` → `IDX_0` goes 0xFFFE, 0xFFFF, 0x0000, with no X and no stall.
